// File: rtl/phys_reg_ready_table_pkg.sv
// Shared types and sizing for the physical register ready table.
// phys_addr_t width is tied to PHYS_REGS so address and table size cannot drift apart.
package phys_reg_ready_table_pkg;

  localparam int unsigned PHYS_REGS        = 64;
  localparam int unsigned ADDR_W           = $clog2(PHYS_REGS);
  localparam int unsigned PRT_MAX_WB_PORTS = 3;
  localparam int unsigned PRT_NUM_RS       = 2;

  typedef logic [ADDR_W-1:0] phys_addr_t;
  typedef logic [ADDR_W:0]   busy_count_t;

  // Entry 0 is the hard-wired zero register and never takes part in tracking.
  function automatic logic [PHYS_REGS-1:0] addr_onehot(input phys_addr_t addr, input logic valid);
    logic [PHYS_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = valid;
    vec[0]    = 1'b0;
    return vec;
  endfunction

endpackage

// File: rtl/phys_reg_ready_table_if.sv
// Rename / writeback / lookup bundle between the pipeline (master) and the ready table (slave).
interface phys_reg_ready_table_if
  import phys_reg_ready_table_pkg::*;
#(
  parameter int unsigned NUM_RS = PRT_NUM_RS,
  parameter int unsigned NUM_WB = PRT_MAX_WB_PORTS
);

  logic                    init_clear;
  logic                    rename_valid;
  phys_addr_t              rename_phys_rd;
  logic                    rollback_valid;
  phys_addr_t              rollback_phys_rd;
  logic       [NUM_WB-1:0] wb_valid;
  phys_addr_t [NUM_WB-1:0] wb_phys_rd;
  logic                    rs_lookup_en;
  phys_addr_t [NUM_RS-1:0] rs_phys;
  logic       [NUM_RS-1:0] rs_ready;
  busy_count_t             busy_count;
  logic                    double_alloc_err;

  modport master (
    output init_clear, rename_valid, rename_phys_rd, rollback_valid, rollback_phys_rd,
    output wb_valid, wb_phys_rd, rs_lookup_en, rs_phys,
    input  rs_ready, busy_count, double_alloc_err
  );

  modport slave (
    input  init_clear, rename_valid, rename_phys_rd, rollback_valid, rollback_phys_rd,
    input  wb_valid, wb_phys_rd, rs_lookup_en, rs_phys,
    output rs_ready, busy_count, double_alloc_err
  );

endinterface

// File: rtl/phys_reg_ready_table_wb_hit_decoder.sv
// Folds the writeback ports into a per-entry clear vector and per-source hit flags.
module phys_reg_ready_table_wb_hit_decoder
  import phys_reg_ready_table_pkg::*;
#(
  parameter int unsigned NUM_WB = PRT_MAX_WB_PORTS,
  parameter int unsigned NUM_RS = PRT_NUM_RS
) (
  input  logic       [NUM_WB-1:0]    wb_valid_i,
  input  phys_addr_t [NUM_WB-1:0]    wb_phys_rd_i,
  input  phys_addr_t [NUM_RS-1:0]    query_addr_i,
  output logic       [PHYS_REGS-1:0] clear_o,
  output logic       [NUM_RS-1:0]    query_hit_o
);

  always_comb begin
    clear_o     = '0;
    query_hit_o = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      clear_o = clear_o | addr_onehot(wb_phys_rd_i[k], wb_valid_i[k]);
    end
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (wb_valid_i[k] && (wb_phys_rd_i[k] == query_addr_i[i])) begin
          query_hit_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phys_reg_ready_table.sv
// Per-physical-register busy tracking with a registered source-readiness lookup for issue.
// Busy bits are set by rename and cleared by rollback/writeback; entry 0 is always ready.
module phys_reg_ready_table
  import phys_reg_ready_table_pkg::*;
#(
  parameter int unsigned NUM_RS = PRT_NUM_RS,
  parameter int unsigned NUM_WB = PRT_MAX_WB_PORTS
) (
  input logic                         clk,
  input logic                         rst,
  phys_reg_ready_table_if.slave       bus
);

  logic        [PHYS_REGS-1:0] busy_q, busy_d;
  logic        [PHYS_REGS-1:0] wb_clear, rollback_clear, rename_set, released;
  phys_addr_t  [NUM_RS-1:0]    rs_addr_q, rs_addr_d, query_addr;
  logic        [NUM_RS-1:0]    rs_ready_q, rs_ready_d, query_hit;
  busy_count_t                 count_q, count_d, dec;
  logic                        inc;
  logic                        err_q, err_d;

  // While holding, the decoder watches the captured addresses for sticky-set hits.
  assign query_addr = bus.rs_lookup_en ? bus.rs_phys : rs_addr_q;

  phys_reg_ready_table_wb_hit_decoder #(
    .NUM_WB (NUM_WB),
    .NUM_RS (NUM_RS)
  ) u_wb_hit_decoder (
    .wb_valid_i   (bus.wb_valid),
    .wb_phys_rd_i (bus.wb_phys_rd),
    .query_addr_i (query_addr),
    .clear_o      (wb_clear),
    .query_hit_o  (query_hit)
  );

  assign rename_set     = addr_onehot(bus.rename_phys_rd, bus.rename_valid);
  assign rollback_clear = addr_onehot(bus.rollback_phys_rd, bus.rollback_valid);
  // Only entries that were busy and are not re-claimed by rename this cycle reduce the count.
  assign released       = (wb_clear | rollback_clear) & busy_q & ~rename_set;
  assign inc            = |(rename_set & ~busy_q);

  always_comb begin
    dec = '0;
    for (int unsigned e = 0; e < PHYS_REGS; e++) begin
      dec = dec + busy_count_t'(released[e]);
    end
  end

  always_comb begin
    busy_d  = '0;
    count_d = '0;
    err_d   = err_q;
    if (!bus.init_clear) begin
      busy_d  = (busy_q & ~(wb_clear | rollback_clear)) | rename_set;
      count_d = count_q + busy_count_t'(inc) - dec;
      err_d   = err_q | (|(rename_set & busy_q));
    end
  end

  always_comb begin
    rs_addr_d  = bus.rs_lookup_en ? bus.rs_phys : rs_addr_q;
    rs_ready_d = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (bus.init_clear) begin
        rs_ready_d[i] = 1'b0;
      end else if (bus.rs_lookup_en) begin
        rs_ready_d[i] = (bus.rs_phys[i] == '0) | ~busy_q[bus.rs_phys[i]] | query_hit[i];
      end else begin
        rs_ready_d[i] = rs_ready_q[i] | query_hit[i] |
                        (bus.rollback_valid && (bus.rollback_phys_rd == rs_addr_q[i]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      rs_addr_q  <= '0;
      rs_ready_q <= '0;
    end else begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      err_q      <= err_d;
      rs_addr_q  <= rs_addr_d;
      rs_ready_q <= rs_ready_d;
    end
  end

  assign bus.rs_ready         = rs_ready_q;
  assign bus.busy_count       = count_q;
  assign bus.double_alloc_err = err_q;

endmodule

// File: tb/tb_phys_reg_ready_table.sv
// Bench for phys_reg_ready_table: directed vector table, hand sequences, then random vs a set model.
module tb_phys_reg_ready_table;
  import phys_reg_ready_table_pkg::*;

  localparam int unsigned NRS = 2;
  localparam int unsigned NWB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_ready_table_if #(.NUM_RS(NRS), .NUM_WB(NWB)) bus ();

  phys_reg_ready_table #(.NUM_RS(NRS), .NUM_WB(NWB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit           init;
    bit           ren_v;
    int           ren;
    bit           rb_v;
    int           rb;
    bit [NWB-1:0] wbv;
    int           wb[NWB];
    bit           lk;
    int           rs[NRS];
  } stim_t;

  typedef struct {
    stim_t        st;
    bit [NRS-1:0] exp_rdy;
    int           exp_cnt;
    bit           exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: a set of busy registers plus the captured lookup state.
  bit           m_busy[PHYS_REGS];
  bit [NRS-1:0] m_rdy;
  int           m_cap[NRS];
  bit           m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int e = 0; e < int'(PHYS_REGS); e++) if (m_busy[e]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < int'(PHYS_REGS); e++) m_busy[e] = 1'b0;
    m_rdy = '0;
    m_err = 1'b0;
    for (int i = 0; i < int'(NRS); i++) m_cap[i] = 0;
  endtask

  task automatic model_step(input stim_t s);
    bit hit;
    int addr;
    if (s.init) begin
      for (int e = 0; e < int'(PHYS_REGS); e++) m_busy[e] = 1'b0;
      m_rdy = '0;
      if (s.lk) for (int i = 0; i < int'(NRS); i++) m_cap[i] = s.rs[i];
      return;
    end
    for (int i = 0; i < int'(NRS); i++) begin
      addr = s.lk ? s.rs[i] : m_cap[i];
      hit  = 1'b0;
      for (int k = 0; k < int'(NWB); k++) if (s.wbv[k] && s.wb[k] == addr) hit = 1'b1;
      if (s.lk) begin
        m_rdy[i] = (addr == 0) || !m_busy[addr] || hit;
        m_cap[i] = addr;
      end else begin
        m_rdy[i] = m_rdy[i] || hit || (s.rb_v && s.rb == addr);
      end
    end
    if (s.ren_v && s.ren != 0 && m_busy[s.ren]) m_err = 1'b1;
    for (int k = 0; k < int'(NWB); k++) if (s.wbv[k] && s.wb[k] != 0) m_busy[s.wb[k]] = 1'b0;
    if (s.rb_v && s.rb != 0) m_busy[s.rb] = 1'b0;
    if (s.ren_v && s.ren != 0) m_busy[s.ren] = 1'b1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.init = 0; s.ren_v = 0; s.ren = 0; s.rb_v = 0; s.rb = 0; s.wbv = '0; s.lk = 0;
    for (int k = 0; k < int'(NWB); k++) s.wb[k] = 0;
    for (int i = 0; i < int'(NRS); i++) s.rs[i] = 0;
    return s;
  endfunction

  function automatic vec_t mk(input bit init, input bit ren_v, input int ren, input bit rb_v,
                              input int rb, input bit [2:0] wbv, input int w0, input int w1,
                              input int w2, input bit lk, input int r0, input int r1,
                              input bit [1:0] er, input int ec, input bit ee);
    vec_t v;
    v.st = idle();
    v.st.init = init; v.st.ren_v = ren_v; v.st.ren = ren; v.st.rb_v = rb_v; v.st.rb = rb;
    v.st.wbv = wbv; v.st.wb[0] = w0; v.st.wb[1] = w1; v.st.wb[2] = w2;
    v.st.lk = lk; v.st.rs[0] = r0; v.st.rs[1] = r1;
    v.exp_rdy = er; v.exp_cnt = ec; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    bus.init_clear       = s.init;
    bus.rename_valid     = s.ren_v;
    bus.rename_phys_rd   = phys_addr_t'(s.ren);
    bus.rollback_valid   = s.rb_v;
    bus.rollback_phys_rd = phys_addr_t'(s.rb);
    bus.wb_valid         = s.wbv;
    for (int k = 0; k < int'(NWB); k++) bus.wb_phys_rd[k] = phys_addr_t'(s.wb[k]);
    bus.rs_lookup_en     = s.lk;
    for (int i = 0; i < int'(NRS); i++) bus.rs_phys[i] = phys_addr_t'(s.rs[i]);
  endtask

  // Called just after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input stim_t s);
    drive(s);
    @(posedge clk);
    model_step(s);
    #1;
    drive(idle());
  endtask

  task automatic rename(input int a);
    stim_t s;
    s = idle(); s.ren_v = 1; s.ren = a;
    cycle(s);
  endtask

  function automatic int raddr();
    if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, 63));
  endfunction

  vec_t  vecs[$];
  stim_t s;

  initial begin
    rst = 1'b0;
    drive(idle());
    model_reset();
    #16 rst = 1'b1;
    check("reset rs_ready", bus.rs_ready, 0);
    check("reset busy_count", bus.busy_count, 0);
    check("reset err", bus.double_alloc_err, 0);
    @(posedge clk); #1;

    //       init ren  a   rb  a  wbv     w0  w1  w2  lk  r0  r1  rdy    cnt err
    vecs.push_back(mk(0, 1, 37, 0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  3'b000, 0,  0,  0,  1, 37, 5,  2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  3'b100, 0,  0,  37, 0, 0,  0,  2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 40, 0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b11, 1, 0));
    vecs.push_back(mk(0, 1, 41, 0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b11, 2, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  3'b001, 40, 0,  0,  1, 40, 41, 2'b01, 1, 0));
    vecs.push_back(mk(0, 1, 12, 0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b01, 2, 0));
    vecs.push_back(mk(0, 1, 12, 0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b01, 2, 1));
    vecs.push_back(mk(0, 1, 0,  0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b01, 2, 1));
    vecs.push_back(mk(0, 1, 20, 0, 0,  3'b011, 12, 41, 0,  0, 0,  0,  2'b11, 1, 1));
    vecs.push_back(mk(0, 1, 21, 0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b11, 2, 1));
    vecs.push_back(mk(0, 1, 22, 0, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b11, 3, 1));
    vecs.push_back(mk(0, 0, 0,  1, 21, 3'b011, 20, 20, 0,  0, 0,  0,  2'b11, 1, 1));
    vecs.push_back(mk(0, 1, 30, 0, 0,  3'b001, 30, 0,  0,  0, 0,  0,  2'b11, 2, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0,  3'b000, 0,  0,  0,  1, 30, 22, 2'b00, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0,  3'b001, 30, 0,  0,  0, 0,  0,  2'b01, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0,  3'b000, 0,  0,  0,  1, 0,  63, 2'b11, 0, 1));
    vecs.push_back(mk(0, 0, 0,  1, 0,  3'b000, 0,  0,  0,  0, 0,  0,  2'b11, 0, 1));

    foreach (vecs[v]) begin
      cycle(vecs[v].st);
      check($sformatf("vec[%0d] rs_ready", v), bus.rs_ready, vecs[v].exp_rdy);
      check($sformatf("vec[%0d] busy_count", v), bus.busy_count, vecs[v].exp_cnt);
      check($sformatf("vec[%0d] err", v), bus.double_alloc_err, vecs[v].exp_err);
    end

    // Asynchronous reset between clock edges.
    rename(37);
    rename(38);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check("async reset rs_ready", bus.rs_ready, 0);
    check("async reset busy_count", bus.busy_count, 0);
    check("async reset err", bus.double_alloc_err, 0);
    #2 rst = 1'b1;
    s = idle(); s.lk = 1; s.rs[0] = 37; s.rs[1] = 38;
    cycle(s);
    check("post-reset lookup", bus.rs_ready, 2'b11);

    // Fill every trackable entry: count tops out at PHYS_REGS-1.
    for (int e = 1; e < int'(PHYS_REGS); e++) rename(e);
    check("full busy_count", bus.busy_count, PHYS_REGS - 1);
    check("full err", bus.double_alloc_err, 0);
    rename(5);
    check("full re-rename err", bus.double_alloc_err, 1);
    check("full re-rename count", bus.busy_count, PHYS_REGS - 1);
    s = idle(); s.init = 1;
    cycle(s);
    check("init_clear count", bus.busy_count, 0);
    check("init_clear keeps err", bus.double_alloc_err, 1);

    // Randomized traffic against the model.
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.init  = ($urandom_range(0, 31) == 0);
      s.ren_v = $urandom_range(0, 1);
      s.ren   = raddr();
      s.rb_v  = ($urandom_range(0, 3) == 0);
      s.rb    = raddr();
      s.wbv   = NWB'($urandom_range(0, 7));
      for (int k = 0; k < int'(NWB); k++) s.wb[k] = raddr();
      s.lk    = $urandom_range(0, 1);
      for (int i = 0; i < int'(NRS); i++) s.rs[i] = raddr();
      cycle(s);
      check($sformatf("rand[%0d] rs_ready", n), bus.rs_ready, m_rdy);
      check($sformatf("rand[%0d] busy_count", n), bus.busy_count, m_count());
      check($sformatf("rand[%0d] err", n), bus.double_alloc_err, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
